// File: rtl/ysyx_22040125_imem_pkg.sv
// Shared types and defaults for the instruction-RAM arbiter slice.
package ysyx_22040125_imem_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_e;

    typedef enum logic {
        OWN_IF,
        OWN_LD
    } owner_e;

    localparam int          ADDR_W_DEF = 16;
    localparam logic [63:0] BASE_DEF   = 64'h8000_0000;

endpackage

// File: rtl/ysyx_22040125_imem_arbiter_if.sv
// Request/response/RAM bundle; slave is the arbiter side, master the fetch/loader/RAM side.
interface ysyx_22040125_imem_arbiter_if #(
    parameter int ADDR_W = 16
);
    logic              if_req_valid;
    logic              if_req_ready;
    logic [63:0]       if_req_pc;
    logic              if_rsp_valid;
    logic              if_rsp_ready;
    logic [31:0]       if_rsp_inst;
    logic [63:0]       if_rsp_pc;
    logic              if_rsp_err;

    logic              ld_req_valid;
    logic              ld_req_ready;
    logic              ld_req_we;
    logic [63:0]       ld_req_addr;
    logic [31:0]       ld_req_wdata;
    logic              ld_rsp_valid;
    logic              ld_rsp_ready;
    logic [31:0]       ld_rsp_rdata;
    logic              ld_rsp_err;

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;

    modport slave (
        input  if_req_valid, if_req_pc, if_rsp_ready,
        input  ld_req_valid, ld_req_we, ld_req_addr, ld_req_wdata, ld_rsp_ready,
        input  mem_rdata,
        output if_req_ready, if_rsp_valid, if_rsp_inst, if_rsp_pc, if_rsp_err,
        output ld_req_ready, ld_rsp_valid, ld_rsp_rdata, ld_rsp_err,
        output mem_en, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output if_req_valid, if_req_pc, if_rsp_ready,
        output ld_req_valid, ld_req_we, ld_req_addr, ld_req_wdata, ld_rsp_ready,
        output mem_rdata,
        input  if_req_ready, if_rsp_valid, if_rsp_inst, if_rsp_pc, if_rsp_err,
        input  ld_req_ready, ld_rsp_valid, ld_rsp_rdata, ld_rsp_err,
        input  mem_en, mem_we, mem_addr, mem_wdata
    );

endinterface

// File: rtl/ysyx_22040125_imem_xlate.sv
// Byte address to RAM word index, flagging out-of-window and misaligned addresses.
module ysyx_22040125_imem_xlate
    import ysyx_22040125_imem_pkg::*;
#(
    parameter int          ADDR_W = ADDR_W_DEF,
    parameter logic [63:0] BASE   = BASE_DEF
) (
    input  logic [63:0]       addr,
    output logic [ADDR_W-1:0] idx,
    output logic              err
);
    logic [63:0] off;

    assign off = addr - BASE;
    assign idx = off[ADDR_W+1:2];
    // BASE is word aligned, so the low offset bits are the address alignment bits
    assign err = (addr < BASE) | (|off[63:ADDR_W+2]) | (|off[1:0]);

endmodule

// File: rtl/ysyx_22040125_imem_arbiter.sv
// Round-robin sharing of the single-port instruction RAM between fetch and loader.
// state | meaning
// IDLE  | grant a requester, issue the RAM command in the accept cycle
// WAIT  | RAM read data arrives, load the owner's response register
// RESP  | hold the owner's response until it is taken
module ysyx_22040125_imem_arbiter
    import ysyx_22040125_imem_pkg::*;
#(
    parameter int          ADDR_W = ADDR_W_DEF,
    parameter logic [63:0] BASE   = BASE_DEF
) (
    input  logic                          clk,
    input  logic                          rst,
    ysyx_22040125_imem_arbiter_if.slave   bus
);
    state_e            state;
    owner_e            last;
    owner_e            owner;
    logic              lat_we;
    logic              lat_err;
    logic [63:0]       lat_pc;

    logic              idle;
    logic              sel_ld;
    logic              hs;
    logic [63:0]       req_addr;
    logic [ADDR_W-1:0] req_idx;
    logic              req_err;
    logic [31:0]       cap_data;

    assign idle   = (state == IDLE) & ~rst;
    // loader wins when alone, or on a tie when fetch had the previous grant
    assign sel_ld = bus.ld_req_valid & (~bus.if_req_valid | (last == OWN_IF));

    assign bus.if_req_ready = idle & bus.if_req_valid & ~sel_ld;
    assign bus.ld_req_ready = idle & sel_ld;

    assign hs       = (bus.if_req_valid & bus.if_req_ready) | (bus.ld_req_valid & bus.ld_req_ready);
    assign req_addr = sel_ld ? bus.ld_req_addr : bus.if_req_pc;

    ysyx_22040125_imem_xlate #(
        .ADDR_W (ADDR_W),
        .BASE   (BASE)
    ) u_xlate (
        .addr (req_addr),
        .idx  (req_idx),
        .err  (req_err)
    );

    assign bus.mem_en    = hs & ~req_err;
    assign bus.mem_we    = hs & sel_ld & bus.ld_req_we;
    assign bus.mem_addr  = hs ? req_idx : '0;
    assign bus.mem_wdata = (hs & sel_ld) ? bus.ld_req_wdata : 32'h0;

    assign cap_data = (lat_we | lat_err) ? 32'h0 : bus.mem_rdata;

    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= IDLE;
            last             <= OWN_LD;
            owner            <= OWN_IF;
            lat_we           <= 1'b0;
            lat_err          <= 1'b0;
            lat_pc           <= 64'h0;
            bus.if_rsp_valid <= 1'b0;
            bus.if_rsp_inst  <= 32'h0;
            bus.if_rsp_pc    <= 64'h0;
            bus.if_rsp_err   <= 1'b0;
            bus.ld_rsp_valid <= 1'b0;
            bus.ld_rsp_rdata <= 32'h0;
            bus.ld_rsp_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (hs) begin
                        state   <= WAIT;
                        owner   <= sel_ld ? OWN_LD : OWN_IF;
                        last    <= sel_ld ? OWN_LD : OWN_IF;
                        lat_we  <= sel_ld & bus.ld_req_we;
                        lat_err <= req_err;
                        lat_pc  <= bus.if_req_pc;
                    end
                end
                WAIT: begin
                    state <= RESP;
                    if (owner == OWN_IF) begin
                        bus.if_rsp_valid <= 1'b1;
                        bus.if_rsp_inst  <= cap_data;
                        bus.if_rsp_pc    <= lat_pc;
                        bus.if_rsp_err   <= lat_err;
                    end else begin
                        bus.ld_rsp_valid <= 1'b1;
                        bus.ld_rsp_rdata <= cap_data;
                        bus.ld_rsp_err   <= lat_err;
                    end
                end
                RESP: begin
                    if ((owner == OWN_IF) ? bus.if_rsp_ready : bus.ld_rsp_ready) begin
                        bus.if_rsp_valid <= 1'b0;
                        bus.ld_rsp_valid <= 1'b0;
                        state            <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ysyx_22040125_imem_arbiter.sv
// Bench for the imem arbiter: transaction-level reference model plus directed and random traffic.
module tb_ysyx_22040125_imem_arbiter;
    localparam int          AW   = 16;
    localparam logic [63:0] BASE = 64'h8000_0000;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ysyx_22040125_imem_arbiter_if #(.ADDR_W(AW)) bus ();

    ysyx_22040125_imem_arbiter #(.ADDR_W(AW), .BASE(BASE)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    endtask

    // environment RAM (written only through the DUT's mem_* port) and reference memory
    logic [31:0] env_ram [longint];
    logic [31:0] ref_mem [longint];

    function automatic logic [31:0] init_word(input longint i);
        return (32'(i) * 32'h9E37_79B1) ^ 32'h5A5A_0000;
    endfunction

    function automatic logic [31:0] env_rd(input longint i);
        return env_ram.exists(i) ? env_ram[i] : init_word(i);
    endfunction

    function automatic logic [31:0] ref_rd(input longint i);
        return ref_mem.exists(i) ? ref_mem[i] : init_word(i);
    endfunction

    function automatic bit ref_err(input logic [63:0] a);
        return (a < BASE) || (a >= BASE + 64'd4 * (64'd1 << AW)) || (a % 4 != 0);
    endfunction

    function automatic longint ref_idx(input logic [63:0] a);
        return longint'((a - BASE) / 4);
    endfunction

    // reference: one outstanding transaction, response visible from 2 cycles after accept
    bit          m_busy     = 1'b0;
    int          m_owner    = 0;
    int          m_last     = 1;
    int          m_age      = 0;
    logic [31:0] m_data     = '0;
    bit          m_err      = 1'b0;
    logic [63:0] m_pc       = '0;
    bit          m_rst_held = 1'b0;

    task automatic step();
        int          win;
        bit          e;
        logic [63:0] a;
        bit          r, ifv, ldv, we, if_rr, ld_rr;
        logic [63:0] pc, la;
        logic [31:0] wd;
        bit          c_en, c_we, exp_ifv, exp_ldv;
        logic [AW-1:0] c_addr;
        logic [31:0] c_wd;

        @(negedge clk);
        r = rst; ifv = bus.if_req_valid; ldv = bus.ld_req_valid; we = bus.ld_req_we;
        pc = bus.if_req_pc; la = bus.ld_req_addr; wd = bus.ld_req_wdata;
        if_rr = bus.if_rsp_ready; ld_rr = bus.ld_rsp_ready;
        win = -1;
        e = 1'b0;
        a = '0;
        if (r) begin
            check("rst_if_req_ready", 64'(bus.if_req_ready), 64'd0);
            check("rst_ld_req_ready", 64'(bus.ld_req_ready), 64'd0);
            check("rst_mem_en", 64'(bus.mem_en), 64'd0);
            if (m_rst_held) begin
                check("rst_if_rsp_valid", 64'(bus.if_rsp_valid), 64'd0);
                check("rst_ld_rsp_valid", 64'(bus.ld_rsp_valid), 64'd0);
                check("rst_if_rsp_inst", 64'(bus.if_rsp_inst), 64'd0);
                check("rst_if_rsp_pc", bus.if_rsp_pc, 64'd0);
                check("rst_ld_rsp_rdata", 64'(bus.ld_rsp_rdata), 64'd0);
                check("rst_errs", 64'({bus.if_rsp_err, bus.ld_rsp_err}), 64'd0);
                check("rst_mem_cmd", 64'({bus.mem_we, bus.mem_addr, bus.mem_wdata}), 64'd0);
            end
        end else begin
            if (!m_busy) begin
                if (ifv && ldv) win = (m_last == 1) ? 0 : 1;
                else if (ifv)   win = 0;
                else if (ldv)   win = 1;
            end
            check("if_req_ready", 64'(bus.if_req_ready), 64'(win == 0));
            check("ld_req_ready", 64'(bus.ld_req_ready), 64'(win == 1));
            if (win >= 0) begin
                a = (win == 1) ? la : pc;
                e = ref_err(a);
                check("mem_en", 64'(bus.mem_en), 64'(!e));
                if (!e) begin
                    check("mem_addr", 64'(bus.mem_addr), 64'(ref_idx(a)));
                    check("mem_we", 64'(bus.mem_we), 64'(win == 1 && we));
                    if (win == 1 && we) check("mem_wdata", 64'(bus.mem_wdata), 64'(wd));
                end
            end else begin
                check("mem_en_idle", 64'(bus.mem_en), 64'd0);
            end
            exp_ifv = m_busy && m_owner == 0 && m_age >= 2;
            exp_ldv = m_busy && m_owner == 1 && m_age >= 2;
            check("if_rsp_valid", 64'(bus.if_rsp_valid), 64'(exp_ifv));
            check("ld_rsp_valid", 64'(bus.ld_rsp_valid), 64'(exp_ldv));
            if (exp_ifv) begin
                check("if_rsp_inst", 64'(bus.if_rsp_inst), 64'(m_data));
                check("if_rsp_pc", bus.if_rsp_pc, m_pc);
                check("if_rsp_err", 64'(bus.if_rsp_err), 64'(m_err));
            end
            if (exp_ldv) begin
                check("ld_rsp_rdata", 64'(bus.ld_rsp_rdata), 64'(m_data));
                check("ld_rsp_err", 64'(bus.ld_rsp_err), 64'(m_err));
            end
        end
        c_en = bus.mem_en; c_we = bus.mem_we; c_addr = bus.mem_addr; c_wd = bus.mem_wdata;

        @(posedge clk);
        #1;
        if (c_en && c_we) env_ram[longint'(c_addr)] = c_wd;
        bus.mem_rdata = (c_en && !c_we) ? env_rd(longint'(c_addr)) : $urandom;

        if (r) begin
            m_busy = 1'b0; m_last = 1; m_rst_held = 1'b1;
        end else begin
            m_rst_held = 1'b0;
            if (win >= 0) begin
                m_busy = 1'b1; m_owner = win; m_last = win; m_age = 1; m_pc = pc;
                if (e) begin
                    m_err = 1'b1; m_data = '0;
                end else begin
                    m_err = 1'b0;
                    if (win == 1 && we) begin
                        ref_mem[ref_idx(a)] = wd;
                        m_data = '0;
                    end else begin
                        m_data = ref_rd(ref_idx(a));
                    end
                end
            end else if (m_busy) begin
                if (m_age >= 2 && ((m_owner == 0) ? if_rr : ld_rr)) m_busy = 1'b0;
                else m_age++;
            end
        end
    endtask

    function automatic logic [63:0] rand_addr();
        case ($urandom_range(0, 9))
            0: return BASE - 64'(4 * $urandom_range(1, 4));
            1: return BASE + (64'd4 << AW) + 64'(4 * $urandom_range(0, 3));
            2: return BASE + 64'(4 * $urandom_range(0, 15)) + 64'($urandom_range(1, 3));
            3: return BASE + (64'd4 << AW) - 64'd4;
            default: return BASE + 64'(4 * $urandom_range(0, 15));
        endcase
    endfunction

    task automatic fetch(input logic [63:0] a, input int tail);
        bus.if_req_valid = 1'b1; bus.if_req_pc = a;
        step();
        bus.if_req_valid = 1'b0;
        repeat (tail) step();
    endtask

    initial begin
        logic [63:0] err_pcs [3];
        err_pcs[0] = 64'h7FFF_FFFC;
        err_pcs[1] = 64'h8004_0000;
        err_pcs[2] = 64'h8000_0002;

        rst = 1'b1;
        bus.if_req_valid = 1'b0; bus.if_req_pc = '0; bus.if_rsp_ready = 1'b1;
        bus.ld_req_valid = 1'b0; bus.ld_req_we = 1'b0; bus.ld_req_addr = '0;
        bus.ld_req_wdata = '0; bus.ld_rsp_ready = 1'b1; bus.mem_rdata = '0;
        repeat (3) step();
        rst = 1'b0;

        // single fetch
        env_ram[0] = 32'h0000_0413; ref_mem[0] = 32'h0000_0413;
        fetch(BASE, 3);

        // loader write then fetch of the same word
        bus.ld_req_valid = 1'b1; bus.ld_req_we = 1'b1;
        bus.ld_req_addr = 64'h8000_0010; bus.ld_req_wdata = 32'hDEAD_BEEF;
        step();
        bus.ld_req_valid = 1'b0;
        repeat (3) step();
        fetch(64'h8000_0010, 3);

        // address errors
        for (int i = 0; i < 3; i++) fetch(err_pcs[i], 3);

        // backpressure on the fetch response while the loader waits
        bus.if_rsp_ready = 1'b0;
        fetch(64'h8000_0008, 0);
        bus.ld_req_valid = 1'b1; bus.ld_req_we = 1'b0; bus.ld_req_addr = 64'h8000_0004;
        repeat (6) step();
        bus.if_rsp_ready = 1'b1;
        repeat (2) step();
        bus.ld_req_valid = 1'b0;
        repeat (3) step();

        // contention from reset
        rst = 1'b1;
        bus.if_req_valid = 1'b1; bus.if_req_pc = 64'h8000_0020;
        bus.ld_req_valid = 1'b1; bus.ld_req_we = 1'b0; bus.ld_req_addr = 64'h8000_0024;
        repeat (2) step();
        rst = 1'b0;
        repeat (12) step();
        bus.if_req_valid = 1'b0; bus.ld_req_valid = 1'b0;
        repeat (3) step();

        // reset while the RAM read is in flight
        fetch(64'h8000_000C, 0);
        rst = 1'b1;
        repeat (2) step();
        rst = 1'b0;
        bus.if_req_valid = 1'b1; bus.ld_req_valid = 1'b1;
        step();
        bus.if_req_valid = 1'b0; bus.ld_req_valid = 1'b0;
        repeat (4) step();

        // random traffic
        for (int n = 0; n < 3000; n++) begin
            rst = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 3) != 0) begin
                bus.if_req_valid = ($urandom_range(0, 2) != 0);
                bus.if_req_pc    = rand_addr();
            end
            if ($urandom_range(0, 3) != 0) begin
                bus.ld_req_valid = ($urandom_range(0, 2) != 0);
                bus.ld_req_we    = $urandom_range(0, 1) == 1;
                bus.ld_req_addr  = rand_addr();
                bus.ld_req_wdata = $urandom;
            end
            bus.if_rsp_ready = ($urandom_range(0, 3) != 0);
            bus.ld_rsp_ready = ($urandom_range(0, 3) != 0);
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/ysyx_22040125_imem_arbiter.md
# ysyx_22040125_imem_arbiter

Shares the single-port synchronous instruction RAM between the fetch stage (IF) and the program loader/debug port (LD). Translates 64-bit byte addresses to RAM word indices, round-robin arbitrates, sequences each access through a three-state FSM, and returns registered responses with valid/ready handshakes. It sits between the fetch unit and the instruction RAM, which it drives as a 1-cycle-read-latency memory.

## Interface
- `ADDR_W`, 16: RAM word-index width; RAM depth is 2^ADDR_W words.
- `BASE`, 64'h8000_0000: byte address of RAM word 0.
- `clk` in 1: single clock, all logic on posedge.
- `rst` in 1: synchronous, active-high reset.
- `if_req_valid` in 1 / `if_req_ready` out 1 / `if_req_pc` in 64: fetch request.
- `if_rsp_valid` out 1 / `if_rsp_ready` in 1 / `if_rsp_inst` out 32 / `if_rsp_pc` out 64 / `if_rsp_err` out 1: fetch response.
- `ld_req_valid` in 1 / `ld_req_ready` out 1 / `ld_req_we` in 1 / `ld_req_addr` in 64 / `ld_req_wdata` in 32: loader request.
- `ld_rsp_valid` out 1 / `ld_rsp_ready` in 1 / `ld_rsp_rdata` out 32 / `ld_rsp_err` out 1: loader response; writes return rdata 0.
- `mem_en` out 1 / `mem_we` out 1 / `mem_addr` out ADDR_W / `mem_wdata` out 32: RAM command, combinational in the accept cycle.
- `mem_rdata` in 32: RAM read data, valid the cycle after `mem_en` with `mem_we`=0.

## Operation
- FSM states: IDLE, WAIT, RESP. Reset enters IDLE.
- IDLE: grant one requester. The grant is combinational from the valids, so `*_req_ready` depends on `*_req_valid`. Only the granted port's ready is 1. The handshake (valid&ready) moves the FSM to WAIT and latches owner, pc/addr, we, and err.
- Round-robin arbitration: `last` records the previous grant. On a tie the other port wins. A lone requester always wins. After reset `last`=LD, so IF wins the first tie.
- Address translation: `idx = (addr - BASE) >> 2`, truncated to ADDR_W bits. The request is an error if addr < BASE, addr ≥ BASE + 4·2^ADDR_W, or addr[1:0] ≠ 0.
  - On error: `mem_en`=0, and the response carries err=1 with data 0.
- RAM command in the accept cycle:
  - `mem_en` = handshake & ~err.
  - `mem_we` = LD & `ld_req_we`.
  - `mem_wdata` = `ld_req_wdata`.
  - IF never writes.
- WAIT: capture `mem_rdata`, or 0 for writes and errors, into the owner's response register. Go to RESP.
- RESP: hold the owner's `*_rsp_valid`=1 with stable data, pc and err until `*_rsp_ready`. On that cycle clear valid and return to IDLE. No new grant is issued in WAIT or RESP.
- `if_rsp_pc` echoes the accepted `if_req_pc`.
- Reset mid-operation drops any outstanding access and its response; it is never delivered.

## Timing
- Request accepted at cycle T; `mem_en` pulses at T; response valid from T+2.
- Next accept is possible no earlier than the cycle after the response handshake. Minimum spacing is 3 cycles per transaction.
- Reset values of all outputs:
  - `*_req_ready`=0 during `rst`.
  - `*_rsp_valid`=0; `if_rsp_inst`, `if_rsp_pc`, `ld_rsp_rdata`=0; `*_rsp_err`=0.
  - `mem_en`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0.
- All response outputs are registered. Req-ready and `mem_*` are combinational from state plus request inputs.
- A requester dropping valid before ready is legal; nothing is latched.
- A requester whose response is still pending is not granted, because the FSM is not in IDLE.

## Structure
- Shared package `ysyx_22040125_imem_pkg` holds:
  - FSM state enum {IDLE, WAIT, RESP};
  - owner encoding {OWN_IF, OWN_LD};
  - default `BASE`/`ADDR_W` constants.
- One natural sub-module, `ysyx_22040125_imem_xlate`: combinational addr → {idx, err}, instantiated once on the muxed request address.
- Everything else (arbiter, FSM, response registers) lives in the top module.

## Test plan
- **Single fetch:** RAM[0]=32'h00000413; IF pc 0x8000_0000 at T.
  - Expect `mem_en`=1 and `mem_addr`=0 at T.
  - Expect `if_rsp_valid` at T+2 with inst 0x00000413, pc 0x8000_0000, err 0.
- **Loader write then fetch:** LD writes 0xDEADBEEF to 0x8000_0010, then IF fetches 0x8000_0010.
  - Expect `mem_we`=1 and `mem_addr`=4 on the write.
  - Expect `ld_rsp_valid` with rdata 0.
  - Expect the fetch to return 0xDEADBEEF.
- **Contention:** both valid continuously from reset, responses always ready.
  - Grants alternate IF, LD, IF, LD.
  - Each is accepted 3 cycles after the previous one.
- **Errors:** IF pc 0x7FFF_FFFC, pc 0x8004_0000 (ADDR_W=16), and pc 0x8000_0002.
  - `mem_en` stays 0 for all three.
  - Each response arrives at T+2 with err=1, inst 0, and the pc echoed.
- **Backpressure:** hold `if_rsp_ready`=0 for 5 cycles while LD is requesting.
  - Response data stays stable and `ld_req_ready` stays 0.
  - LD is accepted the cycle after the IF response handshake.
- **Reset mid-op:** assert `rst` in WAIT.
  - Next cycle all outputs are at their reset values and no response is ever issued.
  - The first post-reset tie is granted to IF.
